// File: rtl/hub75_scan_driver.sv
// HUB75 panel scan driver: reads RGB pixel pairs from the framebuffer, shifts
// them into the panel, latches each row and shows it for a BCM-weighted time.
// Also owns the front/back framebuffer swap, which only happens at a frame end.
module hub75_scan_driver #(
  parameter int N_ROWS_MAX       = 64,
  parameter int N_COLS_MAX       = 256,
  parameter int BITDEPTH_MAX     = 8,
  parameter int CTRL_REG_WIDTH   = 32,
  parameter int MEM_R_ADDR_WIDTH = $clog2(N_ROWS_MAX*N_COLS_MAX)-1,
  parameter int ROW_ADDR_WIDTH   = $clog2(N_ROWS_MAX/2)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_rows,
  input  logic [CTRL_REG_WIDTH-1:0]         ctrl_n_cols,
  input  logic [CTRL_REG_WIDTH-1:0]         ctrl_bitdepth,
  input  logic [CTRL_REG_WIDTH-1:0]         ctrl_oe_base,
  input  logic                              swap_req,
  output logic                              swap_ack,
  output logic                              frame_done,
  output logic                              fb_r_en,
  output logic                              fb_r_buffer,
  output logic [MEM_R_ADDR_WIDTH-1:0]       fb_r_addr,
  output logic [$clog2(BITDEPTH_MAX)-1:0]   fb_r_bit,
  input  logic [5:0]                        fb_r_dout,
  output logic [5:0]                        hub75_rgb,
  output logic                              hub75_clk,
  output logic                              hub75_lat,
  output logic                              hub75_oe_n,
  output logic [ROW_ADDR_WIDTH-1:0]         hub75_addr
);

  localparam int BIT_W  = $clog2(BITDEPTH_MAX);
  localparam int BD_W   = $clog2(BITDEPTH_MAX+1);
  localparam int COL_W  = $clog2(N_COLS_MAX+1);
  localparam int SHC_W  = COL_W+1;
  localparam int HROW_W = $clog2(N_ROWS_MAX/2+1);
  localparam int DISP_W = CTRL_REG_WIDTH+BITDEPTH_MAX;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY} state_t;

  state_t                      state_q, state_d;
  logic [SHC_W-1:0]            sc_q, sc_d;
  logic [DISP_W-1:0]           disp_q, disp_d;
  logic [ROW_ADDR_WIDTH-1:0]   row_q, row_d;
  logic [BIT_W-1:0]            bit_q, bit_d;
  logic [MEM_R_ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [COL_W-1:0]            cols_q, cols_c;
  logic [HROW_W-1:0]           hrows_q, hrows_c;
  logic [BD_W-1:0]             bd_q, bd_c;
  logic [CTRL_REG_WIDTH-1:0]   oe_base_q;
  logic                        buf_q, buf_d;
  logic                        pend_q, pend_d;
  logic                        frame_done_q, frame_done_d;
  logic                        swap_ack_q, swap_ack_d;
  logic [5:0]                  rgb_q, rgb_d;
  logic                        clk_q, clk_d;
  logic                        lat_q, lat_d;
  logic                        oe_n_q, oe_n_d;
  logic [ROW_ADDR_WIDTH-1:0]   addr_q, addr_d;

  logic                        ctrl_ok;
  logic                        capture;
  logic                        plane_end;
  logic                        last_bit;
  logic                        last_row;
  logic                        shift_last;
  logic [DISP_W-1:0]           oe_time;

  // Clamp the live control inputs into the ranges the scan counters support
  always_comb begin
    ctrl_ok = (ctrl_n_cols != '0) && (ctrl_n_rows >= CTRL_REG_WIDTH'(2));
    bd_c    = BD_W'(ctrl_bitdepth);
    if (ctrl_bitdepth == '0)
      bd_c = BD_W'(1);
    else if (ctrl_bitdepth > CTRL_REG_WIDTH'(BITDEPTH_MAX))
      bd_c = BD_W'(BITDEPTH_MAX);
    cols_c = COL_W'(ctrl_n_cols);
    if (ctrl_n_cols > CTRL_REG_WIDTH'(N_COLS_MAX))
      cols_c = COL_W'(N_COLS_MAX);
    hrows_c = HROW_W'(ctrl_n_rows >> 1);
    if (ctrl_n_rows > CTRL_REG_WIDTH'(N_ROWS_MAX))
      hrows_c = HROW_W'(N_ROWS_MAX/2);
  end

  assign shift_last = (sc_q == {cols_q, 1'b0});
  assign oe_time    = DISP_W'(oe_base_q) << bit_q;

  // Next-state logic: scan sequencing, BCM timing, swap handling, panel outputs
  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    disp_d       = disp_q;
    row_d        = row_q;
    bit_d        = bit_q;
    row_base_d   = row_base_q;
    buf_d        = buf_q;
    pend_d       = pend_q | swap_req;
    frame_done_d = 1'b0;
    swap_ack_d   = 1'b0;
    rgb_d        = rgb_q;
    clk_d        = 1'b0;
    addr_d       = addr_q;
    capture      = 1'b0;
    plane_end    = 1'b0;
    last_bit     = (BD_W'(bit_q) == bd_q - BD_W'(1));
    last_row     = (HROW_W'(row_q) == hrows_q - HROW_W'(1));

    unique case (state_q)
      S_IDLE: begin
        row_d      = '0;
        bit_d      = '0;
        row_base_d = '0;
        sc_d       = '0;
        if (enable && ctrl_ok) begin
          capture = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Cycle 0 fills the read latency; odd cycles present data with the
        // panel clock low, the following even cycle raises the clock.
        sc_d  = sc_q + SHC_W'(1);
        clk_d = sc_q[0];
        if (sc_q[0])
          rgb_d = fb_r_dout;
        if (shift_last) begin
          sc_d    = '0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        if (oe_time == '0) begin
          plane_end = 1'b1;
        end else begin
          state_d = S_DISPLAY;
          disp_d  = oe_time - DISP_W'(1);
        end
      end
      S_DISPLAY: begin
        if (disp_q == '0)
          plane_end = 1'b1;
        else
          disp_d = disp_q - DISP_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    if (plane_end) begin
      if (last_bit && last_row) begin
        frame_done_d = 1'b1;
        row_d        = '0;
        bit_d        = '0;
        row_base_d   = '0;
        capture      = 1'b1;
        if (pend_d) begin
          buf_d      = ~buf_q;
          swap_ack_d = 1'b1;
          pend_d     = 1'b0;
        end
        state_d = (enable && ctrl_ok) ? S_SHIFT : S_IDLE;
      end else if (!enable) begin
        state_d    = S_IDLE;
        row_d      = '0;
        bit_d      = '0;
        row_base_d = '0;
      end else begin
        state_d = S_SHIFT;
        if (last_bit) begin
          bit_d      = '0;
          row_d      = row_q + ROW_ADDR_WIDTH'(1);
          row_base_d = row_base_q + MEM_R_ADDR_WIDTH'(cols_q);
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
    end

    lat_d  = (state_d == S_LATCH);
    oe_n_d = (state_d != S_DISPLAY);
    if (state_d == S_LATCH)
      addr_d = row_q;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sc_q         <= '0;
      disp_q       <= '0;
      row_q        <= '0;
      bit_q        <= '0;
      row_base_q   <= '0;
      cols_q       <= '0;
      hrows_q      <= '0;
      bd_q         <= BD_W'(1);
      oe_base_q    <= '0;
      buf_q        <= 1'b0;
      pend_q       <= 1'b0;
      frame_done_q <= 1'b0;
      swap_ack_q   <= 1'b0;
      rgb_q        <= '0;
      clk_q        <= 1'b0;
      lat_q        <= 1'b0;
      oe_n_q       <= 1'b1;
      addr_q       <= '0;
    end else begin
      state_q      <= state_d;
      sc_q         <= sc_d;
      disp_q       <= disp_d;
      row_q        <= row_d;
      bit_q        <= bit_d;
      row_base_q   <= row_base_d;
      buf_q        <= buf_d;
      pend_q       <= pend_d;
      frame_done_q <= frame_done_d;
      swap_ack_q   <= swap_ack_d;
      rgb_q        <= rgb_d;
      clk_q        <= clk_d;
      lat_q        <= lat_d;
      oe_n_q       <= oe_n_d;
      addr_q       <= addr_d;
      if (capture) begin
        cols_q    <= cols_c;
        hrows_q   <= hrows_c;
        bd_q      <= bd_c;
        oe_base_q <= ctrl_oe_base;
      end
    end
  end

  assign fb_r_en     = (state_q == S_SHIFT) && !sc_q[0] && !shift_last;
  assign fb_r_addr   = fb_r_en ? (row_base_q + MEM_R_ADDR_WIDTH'(sc_q[SHC_W-1:1])) : '0;
  assign fb_r_bit    = bit_q;
  assign fb_r_buffer = buf_q;
  // Read data arrives on odd shift cycles; pass it straight through so it is
  // already stable on the cycle before the panel clock rises, then hold it.
  assign hub75_rgb   = ((state_q == S_SHIFT) && sc_q[0]) ? fb_r_dout : rgb_q;
  assign hub75_clk   = clk_q;
  assign hub75_lat   = lat_q;
  assign hub75_oe_n  = oe_n_q;
  assign hub75_addr  = addr_q;
  assign frame_done  = frame_done_q;
  assign swap_ack    = swap_ack_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed testbench for hub75_scan_driver (4x4 panel, 2 bit-planes, oe_base 3).
module tb_hub75_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] ctrl_n_rows = 32'd4;
  logic [31:0] ctrl_n_cols = 32'd4;
  logic [31:0] ctrl_bitdepth = 32'd2;
  logic [31:0] ctrl_oe_base = 32'd3;
  logic        swap_req = 1'b0;
  logic        swap_ack, frame_done, fb_r_en, fb_r_buffer;
  logic [12:0] fb_r_addr;
  logic [2:0]  fb_r_bit;
  logic [5:0]  fb_r_dout = 6'd0;
  logic [5:0]  hub75_rgb;
  logic        hub75_clk, hub75_lat, hub75_oe_n;
  logic [4:0]  hub75_addr;

  int vectors = 0;
  int errors  = 0;
  logic mem_const = 1'b1;

  hub75_scan_driver #(
    .N_ROWS_MAX(64), .N_COLS_MAX(256), .BITDEPTH_MAX(8), .CTRL_REG_WIDTH(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .ctrl_n_rows(ctrl_n_rows), .ctrl_n_cols(ctrl_n_cols),
    .ctrl_bitdepth(ctrl_bitdepth), .ctrl_oe_base(ctrl_oe_base),
    .swap_req(swap_req), .swap_ack(swap_ack), .frame_done(frame_done),
    .fb_r_en(fb_r_en), .fb_r_buffer(fb_r_buffer), .fb_r_addr(fb_r_addr),
    .fb_r_bit(fb_r_bit), .fb_r_dout(fb_r_dout), .hub75_rgb(hub75_rgb),
    .hub75_clk(hub75_clk), .hub75_lat(hub75_lat), .hub75_oe_n(hub75_oe_n),
    .hub75_addr(hub75_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] pix(input int a, input int b, input logic bf);
    return 6'(a * 7) ^ {3'(b), bf, 2'b01};
  endfunction

  // Framebuffer read port model: one cycle of latency
  always @(posedge clk)
    if (fb_r_en)
      fb_r_dout <= mem_const ? 6'b101010 : pix(int'(fb_r_addr), int'(fb_r_bit), fb_r_buffer);

  // Per-frame observations
  int         rd_addr[$];
  int         rd_bit[$];
  int         lat_i[$];
  int         lat_a[$];
  int         oe_run[$];
  logic [5:0] rise_rgb[$];
  logic [5:0] rise_prev[$];
  int         frame_len, oe_bad, lat_long, max_bit, ack_mid, buf_chg, oe_low_total;
  logic       start_buf, end_buf, end_ack;

  // Wait (bounded) for the next negedge on which frame_done is high
  task automatic wait_fd(input int limit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < limit);
    vectors++;
    if (!frame_done) begin
      errors++;
      $display("FAIL wait_frame_done: no frame_done within %0d cycles, required a pulse", limit);
    end
  endtask

  // Called on a frame_done negedge; observes until the next frame_done
  task automatic record_frame(input int limit, input int swap_at);
    int i, run;
    logic pclk, plat;
    logic [5:0] prgb;
    rd_addr.delete(); rd_bit.delete(); lat_i.delete(); lat_a.delete();
    oe_run.delete(); rise_rgb.delete(); rise_prev.delete();
    oe_bad = 0; lat_long = 0; max_bit = 0; ack_mid = 0; buf_chg = 0; oe_low_total = 0;
    start_buf = fb_r_buffer;
    i = 0; run = 0; pclk = hub75_clk; plat = 1'b0; prgb = hub75_rgb;
    while (1) begin
      swap_req = (i == swap_at);
      if (fb_r_en) begin
        rd_addr.push_back(int'(fb_r_addr));
        rd_bit.push_back(int'(fb_r_bit));
      end
      if (hub75_lat) begin
        lat_i.push_back(i);
        lat_a.push_back(int'(hub75_addr));
        if (plat) lat_long++;
      end
      if (!hub75_oe_n) begin
        run++;
        oe_low_total++;
        if (hub75_lat || hub75_clk || fb_r_en) oe_bad++;
      end else if (run > 0) begin
        oe_run.push_back(run);
        run = 0;
      end
      if (hub75_clk && !pclk) begin
        rise_rgb.push_back(hub75_rgb);
        rise_prev.push_back(prgb);
      end
      if (int'(fb_r_bit) > max_bit) max_bit = int'(fb_r_bit);
      if (i > 0 && swap_ack) ack_mid++;
      if (fb_r_buffer !== start_buf) buf_chg++;
      pclk = hub75_clk; plat = hub75_lat; prgb = hub75_rgb;
      @(negedge clk);
      i++;
      if (frame_done || i >= limit) break;
    end
    swap_req = 1'b0;
    if (run > 0) oe_run.push_back(run);
    frame_len = i;
    end_ack = swap_ack;
    end_buf = fb_r_buffer;
    vectors++;
    if (!frame_done) begin
      errors++;
      $display("FAIL frame_timeout: no frame_done within %0d cycles", limit);
    end
  endtask

  task automatic test_reset();
    logic [33:0] got;
    rst_n = 1'b0;
    enable = 1'b0;
    #12;
    got = {hub75_oe_n, hub75_lat, hub75_clk, hub75_rgb, hub75_addr, fb_r_en,
           fb_r_addr, fb_r_bit, fb_r_buffer, frame_done, swap_ack};
    vectors++;
    if (got !== {1'b1, 33'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h required %h", got, {1'b1, 33'd0});
    end
  endtask

  task automatic test_scan_sequence();
    int exp_lat[4] = '{9, 22, 38, 51};
    int exp_la[4]  = '{0, 0, 1, 1};
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    wait_fd(200);
    record_frame(300, -1);
    vectors++;
    if (frame_len !== 58) begin
      errors++;
      $display("FAIL frame_period: got %0d required 58", frame_len);
    end
    vectors++;
    if (rd_addr.size() !== 16) begin
      errors++;
      $display("FAIL read_count: got %0d required 16", rd_addr.size());
    end else begin
      for (int j = 0; j < 16; j++) begin
        vectors++;
        if (rd_addr[j] !== (j / 8) * 4 + j % 4 || rd_bit[j] !== (j / 4) % 2) begin
          errors++;
          $display("FAIL read_%0d: got addr %0d bit %0d required addr %0d bit %0d",
                   j, rd_addr[j], rd_bit[j], (j / 8) * 4 + j % 4, (j / 4) % 2);
        end
      end
    end
    vectors++;
    if (lat_i.size() !== 4) begin
      errors++;
      $display("FAIL latch_count: got %0d required 4", lat_i.size());
    end else begin
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (lat_i[j] !== exp_lat[j] || lat_a[j] !== exp_la[j]) begin
          errors++;
          $display("FAIL latch_%0d: got cycle %0d row %0d required cycle %0d row %0d",
                   j, lat_i[j], lat_a[j], exp_lat[j], exp_la[j]);
        end
      end
    end
  endtask

  task automatic test_shift_data();
    logic [5:0] e;
    mem_const = 1'b1;
    record_frame(300, -1);
    vectors++;
    if (rise_rgb.size() !== 16 || lat_long !== 0 || lat_i.size() !== 4) begin
      errors++;
      $display("FAIL const_shape: got rises %0d lat_long %0d lats %0d required 16 0 4",
               rise_rgb.size(), lat_long, lat_i.size());
    end
    foreach (rise_rgb[j]) begin
      vectors++;
      if (rise_rgb[j] !== 6'b101010 || rise_prev[j] !== 6'b101010) begin
        errors++;
        $display("FAIL const_rise_%0d: got %b prev %b required 101010", j, rise_rgb[j], rise_prev[j]);
      end
    end
    mem_const = 1'b0;
    record_frame(300, -1);
    vectors++;
    if (rise_rgb.size() !== 16) begin
      errors++;
      $display("FAIL pattern_rises: got %0d required 16", rise_rgb.size());
    end else begin
      for (int g = 0; g < 16; g++) begin
        e = pix(((g / 4) / 2) * 4 + g % 4, (g / 4) % 2, start_buf);
        vectors++;
        if (rise_rgb[g] !== e || rise_prev[g] !== e) begin
          errors++;
          $display("FAIL pattern_rise_%0d: got %b prev %b required %b", g, rise_rgb[g], rise_prev[g], e);
        end
      end
    end
  endtask

  task automatic test_oe_timing();
    record_frame(300, -1);
    vectors++;
    if (oe_run.size() !== 4 || oe_run[0] !== 3 || oe_run[1] !== 6 || oe_run[2] !== 3 || oe_run[3] !== 6) begin
      errors++;
      $display("FAIL oe_runs: got %0d runs (%0d total low) required 3,6,3,6", oe_run.size(), oe_low_total);
    end
    vectors++;
    if (oe_bad !== 0) begin
      errors++;
      $display("FAIL oe_overlap: got %0d cycles of oe low during shift/latch required 0", oe_bad);
    end
  endtask

  task automatic test_swap();
    logic b0;
    b0 = fb_r_buffer;
    record_frame(300, 20);
    vectors++;
    if (buf_chg !== 0 || ack_mid !== 0 || end_ack !== 1'b1 || end_buf !== ~b0) begin
      errors++;
      $display("FAIL swap_mid: got chg %0d ackmid %0d ack %b buf %b required 0 0 1 %b",
               buf_chg, ack_mid, end_ack, end_buf, ~b0);
    end
    record_frame(300, 57);
    vectors++;
    if (buf_chg !== 0 || ack_mid !== 0 || end_ack !== 1'b1 || end_buf !== b0) begin
      errors++;
      $display("FAIL swap_at_end: got chg %0d ackmid %0d ack %b buf %b required 0 0 1 %b",
               buf_chg, ack_mid, end_ack, end_buf, b0);
    end
    record_frame(300, -1);
    vectors++;
    if (end_ack !== 1'b0 || end_buf !== b0) begin
      errors++;
      $display("FAIL swap_none: got ack %b buf %b required 0 %b", end_ack, end_buf, b0);
    end
  endtask

  task automatic test_clamp();
    int act;
    ctrl_bitdepth = 32'd0;
    record_frame(300, -1);
    vectors++;
    if (frame_len !== 58) begin
      errors++;
      $display("FAIL ctrl_ignored_midframe: got %0d required 58", frame_len);
    end
    ctrl_bitdepth = 32'd12;
    record_frame(300, -1);
    vectors++;
    if (frame_len !== 26 || max_bit !== 0) begin
      errors++;
      $display("FAIL bitdepth0: got len %0d maxbit %0d required 26 0", frame_len, max_bit);
    end
    record_frame(3000, -1);
    vectors++;
    if (frame_len !== 1690 || max_bit !== 7) begin
      errors++;
      $display("FAIL bitdepth12: got len %0d maxbit %0d required 1690 7", frame_len, max_bit);
    end
    ctrl_bitdepth = 32'd2;
    ctrl_oe_base = 32'd0;
    record_frame(3000, -1);
    record_frame(300, -1);
    vectors++;
    if (frame_len !== 40 || oe_low_total !== 0) begin
      errors++;
      $display("FAIL oe_base0: got len %0d oe_low %0d required 40 0", frame_len, oe_low_total);
    end
    ctrl_n_cols = 32'd0;
    ctrl_oe_base = 32'd3;
    record_frame(300, -1);
    act = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (fb_r_en || frame_done || !hub75_oe_n || hub75_lat) act++;
    end
    vectors++;
    if (act !== 0) begin
      errors++;
      $display("FAIL ncols0_idle: got %0d active cycles required 0", act);
    end
    ctrl_n_cols = 32'd4;
    wait_fd(200);
    record_frame(300, -1);
    vectors++;
    if (frame_len !== 58) begin
      errors++;
      $display("FAIL restart_after_idle: got %0d required 58", frame_len);
    end
  endtask

  task automatic test_enable_drop();
    int rds, oel, fds, n;
    rds = 0; oel = 0; fds = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 2) enable = 1'b0;
      if (fb_r_en) rds++;
      if (!hub75_oe_n) oel++;
      if (i > 0 && frame_done) fds++;
      @(negedge clk);
    end
    vectors++;
    if (rds !== 4 || oel !== 3 || fds !== 0) begin
      errors++;
      $display("FAIL enable_drop: got reads %0d oe_low %0d frames %0d required 4 3 0", rds, oel, fds);
    end
    enable = 1'b1;
    n = 0;
    while (!fb_r_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!fb_r_en || fb_r_addr !== 13'd0 || fb_r_bit !== 3'd0) begin
      errors++;
      $display("FAIL enable_restart: got en %b addr %0d bit %0d required 1 0 0", fb_r_en, fb_r_addr, fb_r_bit);
    end
  endtask

  task automatic test_reset_mid_display();
    logic [33:0] got;
    int n;
    wait_fd(200);
    swap_req = 1'b1;
    @(negedge clk);
    swap_req = 1'b0;
    wait_fd(200);
    vectors++;
    if (fb_r_buffer !== 1'b1 || swap_ack !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_swap: got buf %b ack %b required 1 1", fb_r_buffer, swap_ack);
    end
    n = 0;
    while (hub75_oe_n && n < 100) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (hub75_oe_n) begin
      errors++;
      $display("FAIL find_display: oe_n got 1 required 0 within 100 cycles");
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = {hub75_oe_n, hub75_lat, hub75_clk, hub75_rgb, hub75_addr, fb_r_en,
           fb_r_addr, fb_r_bit, fb_r_buffer, frame_done, swap_ack};
    vectors++;
    if (got !== {1'b1, 33'd0}) begin
      errors++;
      $display("FAIL async_reset: got %h required %h", got, {1'b1, 33'd0});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (!fb_r_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!fb_r_en || fb_r_addr !== 13'd0 || fb_r_bit !== 3'd0 || fb_r_buffer !== 1'b0) begin
      errors++;
      $display("FAIL reset_restart: got en %b addr %0d bit %0d buf %b required 1 0 0 0",
               fb_r_en, fb_r_addr, fb_r_bit, fb_r_buffer);
    end
  endtask

  initial begin
    test_reset();
    test_scan_sequence();
    test_shift_data();
    test_oe_timing();
    test_swap();
    test_clamp();
    test_enable_drop();
    test_reset_mid_display();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
